// File: rtl/serial_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module : serial_tx_pkg
//  Brief  : Shared types and helpers for the serial word transmitter.
//           tx_state_t - transmitter FSM state encoding
//           cnt_w(n)   - counter width for a value range of n (minimum 1 bit)
//  Rev    : 1.0 - initial release
// ============================================================================
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module : bit_tick_gen
//  Brief  : Bit-period divider. Counts 0..DIV-1 while run is high and raises
//           tick combinationally in the cycle the count sits at DIV-1.
//  Ports  : clk  - system clock
//           rst  - synchronous active-high reset
//           clr  - synchronous counter clear (start of a frame)
//           run  - count enable
//           tick - one-cycle strobe at the end of each bit period
//  Rev    : 1.0 - initial release
// ============================================================================
module bit_tick_gen
    import serial_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int                 c_cnt_w = cnt_w(DIV);
    localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= (r_cnt == c_max) ? '0 : r_cnt + c_cnt_w'(1);
        end
    end

    // With DIV = 1 the counter stays at zero and tick simply follows run.
    assign tick = run && (r_cnt == c_max);

endmodule
`default_nettype wire

// File: rtl/serial_word_tx.sv
`default_nettype none
// ============================================================================
//  Module : serial_word_tx
//  Brief  : Accepts a parallel word over valid/ready and serialises it onto
//           sdata, pulsing sen once per bit to clock a downstream serial-in
//           shift register. The bit period is DIV clock cycles.
//  Ports  : clk, rst           - clock, synchronous active-high reset
//           in_valid/in_data   - parallel word offered by upstream
//           in_ready           - word can be accepted (IDLE, not in reset)
//           sdata              - serial bit, held for the whole bit period
//           sen                - one-cycle shift strobe at end of each bit
//           busy               - frame in progress
//           done               - one-cycle pulse after the last strobe
//  Config : define SERIAL_WORD_TX_PARITY_EN to append an even-parity bit
//           (XOR of the word) after the data bits.
//  Rev    : 1.0 - initial release
// ============================================================================
module serial_word_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sdata,
    output logic             sen,
    output logic             busy,
    output logic             done
);

`ifdef SERIAL_WORD_TX_PARITY_EN
    localparam int c_nbits = WIDTH + 1;
`else
    localparam int c_nbits = WIDTH;
`endif
    localparam int                 c_bit_w = cnt_w(WIDTH + 1);
    localparam logic [c_bit_w-1:0] c_last  = c_bit_w'(c_nbits - 1);

    tx_state_t          r_state;
    tx_state_t          w_next;
    logic [WIDTH-1:0]   r_data;
    logic [c_bit_w-1:0] r_bit;
    logic               w_accept;
    logic               w_tick;
    logic               w_data_bit;
    logic               w_cur_bit;

    assign in_ready = (r_state == IDLE) && !rst;
    assign w_accept = in_valid && in_ready;
    assign busy     = (r_state == SHIFT);
    assign done     = (r_state == DONE);
    assign sen      = w_tick;

    // The word register shifts toward the output end on every strobe, so the
    // bit currently on the line is always at a fixed position.
    assign w_data_bit = (MSB_FIRST != 0) ? r_data[WIDTH-1] : r_data[0];

`ifdef SERIAL_WORD_TX_PARITY_EN
    logic r_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= ^in_data;
        end
    end

    assign w_cur_bit = (r_bit == c_bit_w'(WIDTH)) ? r_par : w_data_bit;
`else
    assign w_cur_bit = w_data_bit;
`endif

    assign sdata = (r_state == SHIFT) ? w_cur_bit : 1'b0;

    bit_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_accept),
        .run  (r_state == SHIFT),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data <= in_data;
                r_bit  <= '0;
            end else if (w_tick) begin
                r_data <= (MSB_FIRST != 0) ? {r_data[WIDTH-2:0], 1'b0}
                                           : {1'b0, r_data[WIDTH-1:1]};
                r_bit  <= r_bit + c_bit_w'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = SHIFT;
            SHIFT:   if (w_tick && (r_bit == c_last)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
Upstream feeder for the 4-bit serial-in shift register stage. Accepts a parallel word over a valid/ready handshake and serialises it onto one data line. Emits a one-cycle shift-enable strobe per bit, which drives the downstream register's enable input directly. Bit rate is set by an internal clock divider, so the downstream register shifts at a controlled pace.

Parameters:
WIDTH, 4, data word width in bits; must be >= 2.
DIV, 4, clock cycles per serial bit; must be >= 1.
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first (MSB ends in the downstream register's top bit); 0 = LSB first.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  parallel word present
in_data  input  WIDTH  parallel word
in_ready  output  1  block can accept a word
sdata  output  1  serial bit to the downstream register's d input
sen  output  1  one-cycle shift strobe to the downstream register's enable input
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the last bit's strobe

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset state:
  - FSM goes to IDLE.
  - sdata, sen, busy and done are 0; the data, bit and divider registers clear.
  - in_ready is 0 while rst is high and 1 from the first cycle after rst deasserts.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at an edge: latch in_data, clear the bit and divider counters, go to SHIFT.
- SHIFT:
  - busy = 1, in_ready = 0.
  - sdata holds the current bit for the whole bit period.
  - The divider counts 0..DIV-1; at count DIV-1, sen = 1 for that cycle and the bit counter advances.
  - After the strobe for the last bit, go to DONE.
- DONE:
  - done = 1 for exactly one cycle; busy = 0; then go to IDLE.
- Timing:
  - If the word is accepted at edge 0, strobe k (k = 1..WIDTH) is high in cycle k*DIV.
  - DONE is the cycle after the last strobe.
  - Minimum spacing between accepted words is WIDTH*DIV + 2 cycles.
- DIV = 1: sen is high on every SHIFT cycle.
- in_valid asserted during SHIFT or DONE is ignored; the upstream holds the word until in_ready.
- in_data changing after acceptance has no effect on the frame.
- Reset mid-frame: the frame aborts with no done pulse; sdata and sen return to 0 on that edge.
- sdata in IDLE and DONE: 0.
- Counter widths: $clog2 of (WIDTH+1) and DIV, minimum 1 bit.

Optional Feature:
SERIAL_WORD_TX_PARITY_EN
- Defined: one even-parity bit (XOR of the word) is appended after the data bits. The frame has WIDTH+1 strobes and done follows the parity strobe.
- Undefined: the frame has exactly WIDTH strobes and no parity logic is present.

Decomposition:
- Package serial_tx_pkg contains:
  - typedef enum tx_state_t {IDLE, SHIFT, DONE};
  - localparam function cnt_w(n), giving the counter width.
- One natural sub-module, bit_tick_gen:
  - Parameter DIV.
  - Inputs clk, rst, clr, run; output tick, high at count DIV-1.
  - The top level instantiates it and uses tick as sen.

Test Plan:
1. WIDTH=4, DIV=1, MSB_FIRST=1, send 4'b1011 -> sen high in cycles 1-4, sdata 1,0,1,1, done in cycle 5; the downstream register ends with Q = 4'b1011.
2. DIV=4, send 4'b0110 -> sen only in cycles 4, 8, 12 and 16; sdata stable across each 4-cycle period; done in cycle 17.
3. Back-pressure: hold in_valid with 4'hA, then 4'h5 issued during busy -> 4'h5 is accepted only after done. in_ready is 0 throughout SHIFT/DONE.
4. Assert rst in cycle 6 of a DIV=4 frame -> no further sen, no done pulse; in_ready = 1 in the cycle after rst drops; a new word transmits correctly.
5. MSB_FIRST=0, send 4'b0001 -> sdata 1,0,0,0; the downstream register ends with Q = 4'b1000.
6. With SERIAL_WORD_TX_PARITY_EN defined, send 4'b0111 -> 5 strobes, fifth bit = 1, done after the fifth strobe; send 4'b0011 -> fifth bit = 0.
